// File: rtl/alu_pkg.sv
// Shared ALU op codes, MIPS opcode/funct values, operand-select enums and the
// EX-stage bundle used by alu_issue_stage and alu_op_encode.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDU = 4'h1;
    localparam logic [3:0] OP_SUBU = 4'h2;
    localparam logic [3:0] OP_LUI  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] OP_AND  = 4'hA;
    localparam logic [3:0] OP_XOR  = 4'hB;
    localparam logic [3:0] OP_SRL  = 4'hC;
    localparam logic [3:0] OP_SRA  = 4'hD;
    localparam logic [3:0] OP_NOR  = 4'hE;
    localparam logic [3:0] OP_SLTU = 4'hF;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic {A_RS, A_SHAMT} a_sel_t;
    typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT, B_PC} b_sel_t;
    typedef enum logic [1:0] {RD_RD, RD_RT, RD_RA} rd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
        logic [4:0]      rd;
        logic            regwrite;
        logic            ovf_chk;
        logic            illegal;
        logic [XLEN-1:0] rt_data;
    } ex_bundle_t;

endpackage

// File: rtl/alu_op_encode.sv
// Combinational MIPS decode: opcode/funct to ALU op, operand selects,
// destination select and control flags.
import alu_pkg::*;

module alu_op_encode (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] op,
    output a_sel_t     a_sel,
    output b_sel_t     b_sel,
    output rd_sel_t    rd_sel,
    output logic       writes,
    output logic       ovf_chk,
    output logic       illegal
);

    // Decode table; writes is the raw intent before the rd==0 override.
    always_comb begin
        op      = OP_NOP;
        a_sel   = A_RS;
        b_sel   = B_RT;
        rd_sel  = RD_RD;
        writes  = 1'b0;
        ovf_chk = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                writes = 1'b1;
                case (funct)
                    FN_ADDU: op = OP_ADDU;
                    FN_SUBU: op = OP_SUBU;
                    FN_ADD:  begin op = OP_ADD; ovf_chk = 1'b1; end
                    FN_SUB:  begin op = OP_SUB; ovf_chk = 1'b1; end
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_XOR:  op = OP_XOR;
                    FN_NOR:  op = OP_NOR;
                    FN_SLT:  op = OP_SLT;
                    FN_SLTU: op = OP_SLTU;
                    FN_SLL:  begin op = OP_SLL; a_sel = A_SHAMT; end
                    FN_SRL:  begin op = OP_SRL; a_sel = A_SHAMT; end
                    FN_SRA:  begin op = OP_SRA; a_sel = A_SHAMT; end
                    FN_SLLV: op = OP_SLL;
                    FN_SRLV: op = OP_SRL;
                    FN_SRAV: op = OP_SRA;
                    FN_JALR: begin op = OP_JAL; b_sel = B_PC; end
                    FN_JR:   writes = 1'b0;
                    default: begin writes = 1'b0; illegal = 1'b1; end
                endcase
            end
            OPC_ADDIU: begin op = OP_ADDU; b_sel = B_SEXT; rd_sel = RD_RT; writes = 1'b1; end
            OPC_ADDI:  begin op = OP_ADD;  b_sel = B_SEXT; rd_sel = RD_RT; writes = 1'b1; ovf_chk = 1'b1; end
            OPC_SLTI:  begin op = OP_SLT;  b_sel = B_SEXT; rd_sel = RD_RT; writes = 1'b1; end
            OPC_SLTIU: begin op = OP_SLTU; b_sel = B_SEXT; rd_sel = RD_RT; writes = 1'b1; end
            OPC_ANDI:  begin op = OP_AND;  b_sel = B_ZEXT; rd_sel = RD_RT; writes = 1'b1; end
            OPC_ORI:   begin op = OP_OR;   b_sel = B_ZEXT; rd_sel = RD_RT; writes = 1'b1; end
            OPC_XORI:  begin op = OP_XOR;  b_sel = B_ZEXT; rd_sel = RD_RT; writes = 1'b1; end
            OPC_LUI:   begin op = OP_LUI;  b_sel = B_ZEXT; rd_sel = RD_RT; writes = 1'b1; end
            OPC_LW:    begin op = OP_ADDU; b_sel = B_SEXT; rd_sel = RD_RT; writes = 1'b1; end
            OPC_SW:    begin op = OP_ADDU; b_sel = B_SEXT; rd_sel = RD_RT; end
            OPC_BEQ,
            OPC_BNE:   begin op = OP_SUBU; rd_sel = RD_RT; end
            OPC_JAL:   begin op = OP_JAL;  b_sel = B_PC; rd_sel = RD_RA; writes = 1'b1; end
            default:   begin rd_sel = RD_RT; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand select and the registered EX bundle.
// Optional WB forwarding into rs/rt is enabled by defining ALU_ISSUE_FWD_EN.
import alu_pkg::*;

module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int RA_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
`ifdef ALU_ISSUE_FWD_EN
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
`endif
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_op,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            ex_ovf_chk,
    output logic            ex_illegal,
    output logic [XLEN-1:0] ex_rt_data
);

    logic [3:0]      op_s;
    a_sel_t          a_sel_s;
    b_sel_t          b_sel_s;
    rd_sel_t         rd_sel_s;
    logic            writes_s;
    logic            ovf_chk_s;
    logic            illegal_s;
    logic [XLEN-1:0] rs_val_s;
    logic [XLEN-1:0] rt_val_s;
    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic [4:0]      rd_s;
    ex_bundle_t      next_s;
    ex_bundle_t      bundle_r;

    alu_op_encode u_encode (
        .opcode  (instr[31:26]),
        .funct   (instr[5:0]),
        .op      (op_s),
        .a_sel   (a_sel_s),
        .b_sel   (b_sel_s),
        .rd_sel  (rd_sel_s),
        .writes  (writes_s),
        .ovf_chk (ovf_chk_s),
        .illegal (illegal_s)
    );

`ifdef ALU_ISSUE_FWD_EN
    // WB bypass; $0 is never forwarded since it always reads as zero.
    always_comb begin
        if (wb_fwd_en && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == instr[25:21])) begin
            rs_val_s = wb_fwd_data;
        end else begin
            rs_val_s = rs_data;
        end
        if (wb_fwd_en && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == instr[20:16])) begin
            rt_val_s = wb_fwd_data;
        end else begin
            rt_val_s = rt_data;
        end
    end
`else
    assign rs_val_s = rs_data;
    assign rt_val_s = rt_data;
`endif

    // Operand and destination muxes.
    always_comb begin
        a_sel_case: case (a_sel_s)
            A_SHAMT: a_s = {27'd0, instr[10:6]};
            default: a_s = rs_val_s;
        endcase
        case (b_sel_s)
            B_SEXT:  b_s = {{16{instr[15]}}, instr[15:0]};
            B_ZEXT:  b_s = {16'd0, instr[15:0]};
            B_PC:    b_s = pc;
            default: b_s = rt_val_s;
        endcase
        case (rd_sel_s)
            RD_RT:   rd_s = instr[20:16];
            RD_RA:   rd_s = RA_REG[4:0];
            default: rd_s = instr[15:11];
        endcase
    end

    always_comb begin
        next_s.valid    = 1'b1;
        next_s.a        = a_s;
        next_s.b        = b_s;
        next_s.op       = op_s;
        next_s.rd       = rd_s;
        next_s.regwrite = writes_s && (rd_s != 5'd0);
        next_s.ovf_chk  = ovf_chk_s;
        next_s.illegal  = illegal_s;
        next_s.rt_data  = rt_val_s;
    end

    // EX register: rst > flush > stall > load; empty ID slot loads a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_r <= '0;
        end else if (flush) begin
            bundle_r <= '0;
        end else if (stall) begin
            bundle_r <= bundle_r;
        end else if (!id_valid) begin
            bundle_r <= '0;
        end else begin
            bundle_r <= next_s;
        end
    end

    assign ex_valid    = bundle_r.valid;
    assign ex_a        = bundle_r.a;
    assign ex_b        = bundle_r.b;
    assign ex_op       = bundle_r.op;
    assign ex_rd       = bundle_r.rd;
    assign ex_regwrite = bundle_r.regwrite;
    assign ex_ovf_chk  = bundle_r.ovf_chk;
    assign ex_illegal  = bundle_r.illegal;
    assign ex_rt_data  = bundle_r.rt_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed table-driven bench for alu_issue_stage plus reset/stall/flush
// sequences; forwarding checks only when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_ovf_chk;
    logic        ex_illegal;
    logic [31:0] ex_rt_data;
`ifdef ALU_ISSUE_FWD_EN
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .instr       (instr),
        .pc          (pc),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
`ifdef ALU_ISSUE_FWD_EN
        .wb_fwd_en   (wb_fwd_en),
        .wb_fwd_rd   (wb_fwd_rd),
        .wb_fwd_data (wb_fwd_data),
`endif
        .stall       (stall),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_op       (ex_op),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite),
        .ex_ovf_chk  (ex_ovf_chk),
        .ex_illegal  (ex_illegal),
        .ex_rt_data  (ex_rt_data)
    );

    typedef struct {
        string       name;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        e_valid;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [3:0]  e_op;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_ovf;
        logic        e_ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op, input logic [4:0] rd,
                           input logic rw, input logic ovf, input logic ill, input logic [31:0] rtd);
        chk({tag, ".valid"},    {31'd0, ex_valid},    {31'd0, v});
        chk({tag, ".a"},        ex_a,                 a);
        chk({tag, ".b"},        ex_b,                 b);
        chk({tag, ".op"},       {28'd0, ex_op},       {28'd0, op});
        chk({tag, ".rd"},       {27'd0, ex_rd},       {27'd0, rd});
        chk({tag, ".regwrite"}, {31'd0, ex_regwrite}, {31'd0, rw});
        chk({tag, ".ovf_chk"},  {31'd0, ex_ovf_chk},  {31'd0, ovf});
        chk({tag, ".illegal"},  {31'd0, ex_illegal},  {31'd0, ill});
        chk({tag, ".rt_data"},  ex_rt_data,           rtd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; id_valid = 1'b1; instr = 32'h00A63021; pc = 32'h0000_0400;
        rs_data = 32'd5; rt_data = 32'd7; stall = 1'b0; flush = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
        wb_fwd_en = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd0;
`endif

        // Reset held two cycles with a valid addu on the input, stall/flush ignored.
        step();
        chk_all("rst1", 1'b0, 32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        stall = 1'b1;
        step();
        chk_all("rst2", 1'b0, 32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        stall = 1'b0; rst = 1'b0;
        step();
        chk_all("rst_exit", 1'b1, 32'd5, 32'd7, 4'h1, 5'd6, 1'b1, 1'b0, 1'b0, 32'd7);

        vecs.push_back('{"addu",  1'b1, 32'h00A63021, 32'd5,        32'd7,        1'b1, 32'd5,        32'd7,        4'h1, 5'd6,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"addi",  1'b1, 32'h2022FFFF, 32'd3,        32'd9,        1'b1, 32'd3,        32'hFFFFFFFF, 4'h6, 5'd2,  1'b1, 1'b1, 1'b0});
        vecs.push_back('{"ori",   1'b1, 32'h3422FFFF, 32'h11,       32'h22,       1'b1, 32'h11,       32'h0000FFFF, 4'h4, 5'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sll",   1'b1, 32'h00021100, 32'h55,       32'h3,        1'b1, 32'd4,        32'h3,        4'h5, 5'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"srl31", 1'b1, 32'h00021FC2, 32'h55,       32'h80000000, 1'b1, 32'd31,       32'h80000000, 4'hC, 5'd3,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"srav",  1'b1, 32'h00221807, 32'd8,        32'hF0000000, 1'b1, 32'd8,        32'hF0000000, 4'hD, 5'd3,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"jal",   1'b1, 32'h0C000010, 32'h1,        32'h2,        1'b1, 32'h1,        32'h00000400, 4'h9, 5'd31, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"jalr",  1'b1, 32'h0020F809, 32'h1000,     32'h2,        1'b1, 32'h1000,     32'h00000400, 4'h9, 5'd31, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"jr",    1'b1, 32'h00200008, 32'h1000,     32'h2,        1'b1, 32'h1000,     32'h2,        4'h0, 5'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub",   1'b1, 32'h00221822, 32'd10,       32'd4,        1'b1, 32'd10,       32'd4,        4'h7, 5'd3,  1'b1, 1'b1, 1'b0});
        vecs.push_back('{"nor",   1'b1, 32'h00221827, 32'hA,        32'hB,        1'b1, 32'hA,        32'hB,        4'hE, 5'd3,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sltu",  1'b1, 32'h0022182B, 32'hA,        32'hB,        1'b1, 32'hA,        32'hB,        4'hF, 5'd3,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"lw",    1'b1, 32'h8C22FFF0, 32'h100,      32'h7,        1'b1, 32'h100,      32'hFFFFFFF0, 4'h1, 5'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sw",    1'b1, 32'hAC220004, 32'h100,      32'hCAFE,     1'b1, 32'h100,      32'h00000004, 4'h1, 5'd2,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"beq",   1'b1, 32'h10220003, 32'h6,        32'h6,        1'b1, 32'h6,        32'h6,        4'h2, 5'd2,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"andi",  1'b1, 32'h30228000, 32'hFFFF,     32'h1,        1'b1, 32'hFFFF,     32'h00008000, 4'hA, 5'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"slti",  1'b1, 32'h28228000, 32'h1,        32'h1,        1'b1, 32'h1,        32'hFFFF8000, 4'h8, 5'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sltiu", 1'b1, 32'h2C22FFFF, 32'h1,        32'h1,        1'b1, 32'h1,        32'hFFFFFFFF, 4'hF, 5'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"xori",  1'b1, 32'h38220F0F, 32'h1,        32'h1,        1'b1, 32'h1,        32'h00000F0F, 4'hB, 5'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"lui",   1'b1, 32'h3C021234, 32'h0,        32'h1,        1'b1, 32'h0,        32'h00001234, 4'h3, 5'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"rd0",   1'b1, 32'h00220021, 32'h3,        32'h4,        1'b1, 32'h3,        32'h4,        4'h1, 5'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"ill_op",1'b1, 32'hFC000000, 32'h3,        32'h4,        1'b1, 32'h3,        32'h4,        4'h0, 5'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{"ill_fn",1'b1, 32'h0000003F, 32'h3,        32'h4,        1'b1, 32'h3,        32'h4,        4'h0, 5'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{"bubble",1'b0, 32'h00A63021, 32'h3,        32'h4,        1'b0, 32'h0,        32'h0,        4'h0, 5'd0,  1'b0, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            id_valid = vecs[i].vld;
            instr    = vecs[i].ins;
            rs_data  = vecs[i].rs;
            rt_data  = vecs[i].rt;
            step();
            chk_all(vecs[i].name, vecs[i].e_valid, vecs[i].e_a, vecs[i].e_b, vecs[i].e_op,
                    vecs[i].e_rd, vecs[i].e_rw, vecs[i].e_ovf, vecs[i].e_ill,
                    vecs[i].e_valid ? vecs[i].rt : 32'd0);
        end

        // Stall holds the addi bundle for three cycles while inputs change.
        id_valid = 1'b1; instr = 32'h2022FFFF; rs_data = 32'd3; rt_data = 32'd9;
        step();
        stall = 1'b1; instr = 32'h00A63021; rs_data = 32'd5; rt_data = 32'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("stall%0d", i), 1'b1, 32'd3, 32'hFFFFFFFF, 4'h6, 5'd2,
                    1'b1, 1'b1, 1'b0, 32'd9);
        end
        flush = 1'b1;
        step();
        chk_all("stall_flush", 1'b0, 32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        stall = 1'b0; flush = 1'b0;
        step();
        chk_all("post_flush", 1'b1, 32'd5, 32'd7, 4'h1, 5'd6, 1'b1, 1'b0, 1'b0, 32'd7);
        instr = 32'hFC000000;
        flush = 1'b1;
        step();
        chk_all("flush_ill", 1'b0, 32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        flush = 1'b0;

`ifdef ALU_ISSUE_FWD_EN
        instr = 32'h00A63021; rs_data = 32'd5; rt_data = 32'd7;
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h0000DEAD;
        step();
        chk_all("fwd_rs", 1'b1, 32'h0000DEAD, 32'd7, 4'h1, 5'd6, 1'b1, 1'b0, 1'b0, 32'd7);
        wb_fwd_rd = 5'd6;
        step();
        chk_all("fwd_rt", 1'b1, 32'd5, 32'h0000DEAD, 4'h1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0000DEAD);
        wb_fwd_en = 1'b0; wb_fwd_rd = 5'd5;
        step();
        chk_all("fwd_off", 1'b1, 32'd5, 32'd7, 4'h1, 5'd6, 1'b1, 1'b0, 1'b0, 32'd7);
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd0; instr = 32'h00063021; rs_data = 32'h123;
        step();
        chk_all("fwd_r0", 1'b1, 32'h123, 32'd7, 4'h1, 5'd6, 1'b1, 1'b0, 1'b0, 32'd7);
        wb_fwd_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the pipeline ALU.
- Decodes each MIPS instruction into the 4-bit ALU op code, selects and extends operands A/B, and registers them with destination and control bits for the EX stage.
- Single-cycle issue with stall-hold and flush-bubble control from the hazard unit.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RA_REG, 31, destination register written by jal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  instr/pc/rs_data/rt_data hold a real instruction.
- instr  in  32  instruction word.
- pc  in  32  address of instr.
- rs_data  in  32  register file read of instr[25:21].
- rt_data  in  32  register file read of instr[20:16].
- stall  in  1  hold every EX register.
- flush  in  1  replace the next EX contents with a bubble.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_a  out  32  ALU operand A.
- ex_b  out  32  ALU operand B.
- ex_op  out  4  ALU op code.
- ex_rd  out  5  destination register.
- ex_regwrite  out  1  result is written back.
- ex_ovf_chk  out  1  ALU overflow must raise a trap (add/sub/addi).
- ex_illegal  out  1  unrecognised opcode/funct.
- ex_rt_data  out  32  store data for sw.

Behaviour:
- Reset: all outputs 0 in the cycle after rst is sampled high; rst overrides stall and flush.
- Latency: 1 cycle, input at edge N appears on the outputs after edge N.
- Priority per edge: rst > flush > stall > load.
- Flush: all outputs go to 0, including ex_valid, regwrite and illegal.
- Stall: all outputs hold.
- id_valid=0: loads a bubble, with the same outputs as flush.
- Op codes are shared with the ALU: ADDU 1, SUBU 2, LUI 3, OR 4, SLL 5, ADD 6, SUB 7, SLT 8, JAL 9, AND A, XOR B, SRL C, SRA D, NOR E, SLTU F, NOP 0.
- R-type (opcode 0):
  - Operands: A=rs_data, B=rt_data, rd=instr[15:11].
  - funct 21 ADDU, 23 SUBU, 20 ADD, 22 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
  - Shifts 00/02/03 map to SLL/SRL/SRA with A={27'b0,shamt}.
  - Shifts 04/06/07 map to SLL/SRL/SRA with A=rs_data.
  - jalr (09): JAL, B=pc, rd=instr[15:11].
  - jr (08): NOP, regwrite=0, valid=1.
- I-type: B=imm (sext or zext as listed below), rd=instr[20:16].
  - addiu 09 ADDU sext; addi 08 ADD sext with ovf_chk.
  - slti 0A SLT sext; sltiu 0B SLTU sext.
  - andi 0C AND zext; ori 0D OR zext; xori 0E XOR zext.
  - lui 0F LUI, B=zext imm.
  - lw 23 ADDU sext.
  - sw 2B ADDU sext, regwrite=0.
  - beq 04 / bne 05: SUBU, B=rt_data, regwrite=0.
  - jal 03: JAL, B=pc, rd=RA_REG.
- ovf_chk=1 only for ADD, SUB, addi.
- rd=0 forces regwrite=0.
- Unknown opcode or funct: op=NOP, regwrite=0, illegal=1, valid=1.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: adds inputs wb_fwd_en(1), wb_fwd_rd(5), wb_fwd_data(32).
  - If wb_fwd_en and wb_fwd_rd!=0 and it matches rs, wb_fwd_data replaces rs_data before operand selection.
  - The same rule applies independently for rt.
- Undefined: the ports are absent and register-file data is used as is.

Decomposition:
- Package alu_pkg:
  - ALU op localparams (4-bit).
  - opcode/funct localparams.
  - typedef struct ex_bundle_t {valid,a,b,op,rd,regwrite,ovf_chk,illegal,rt_data}.
- Sub-module alu_op_encode: purely combinational, instr to op/imm-select/rd-select/flags.
- alu_issue_stage: operand muxing, optional forwarding, and the ex_bundle_t register.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1, addu → all outputs 0; first load after rst drops.
- addu: instr 0x00A63021, rs=5, rt=7 → op=1, a=5, b=7, rd=6, regwrite=1, ovf_chk=0.
- addi: 0x2022FFFF (addi $2,$1,-1), rs=3 → op=6, b=0xFFFFFFFF, rd=2, ovf_chk=1.
- ori: 0x3422FFFF → op=4, b=0x0000FFFF.
- sll: 0x00021100 (sll $2,$2,4) → op=5, a=4.
- jal: 0x0C000010 at pc=0x400 → op=9, b=0x400, rd=31, regwrite=1.
- Stall and flush: stall=1 for 3 cycles holds the prior bundle; stall=1 with flush=1 gives ex_valid=0.
- Illegal: opcode 0x3F gives illegal=1 and op=0.
- Forwarding (ALU_ISSUE_FWD_EN): wb_fwd_rd=5, wb_fwd_data=0xDEAD, addu rs=$5 → a=0xDEAD.
- Forwarding to $0: wb_fwd_rd=0 with rs=$0 → a=rs_data.
